// File: rtl/spad_arbiter.sv
// spad_arbiter: N-host to single scratchpad request arbiter with in-order
// response routing.
//   Requests: hosts present packed per-host valid/addr/we/wdata/be. One winner
//   drives dev_*. The grant is held (LOCKED) until dev_req_ready_i accepts it.
//   Responses: each accepted request pushes its winner index into a routing
//   FIFO. Each dev_rsp_valid_i pops the FIFO head and strobes that host.
//   A response that arrives with an empty FIFO is dropped and flagged on
//   unexpected_rsp_o.
// Ports:
//   clk_sys_i, rst_sys_i           clock, synchronous active-high reset
//   host_req_valid_i/_ready_o      per-host request handshake
//   host_addr_i/we_i/wdata_i/be_i  packed per-host request fields
//   host_rsp_valid_o               one-hot response strobe
//   host_rdata_o/host_err_o        shared response payload
//   dev_req_*/dev_addr_o/...       downstream request
//   dev_rsp_valid_i/rdata_i/err_i  downstream in-order response
//   outstanding_o                  in-flight request count
//   unexpected_rsp_o               one-cycle pulse for a response with no owner
// Build option: define SPAD_ARB_FIXED_PRIO_EN to use fixed priority, where
// the lowest index wins. If it is not defined, the arbiter uses round-robin.
module spad_arbiter #(
    parameter int unsigned NumHosts       = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                clk_sys_i,
    input  logic                                rst_sys_i,
    input  logic [NumHosts-1:0]                 host_req_valid_i,
    output logic [NumHosts-1:0]                 host_req_ready_o,
    input  logic [NumHosts*AddrWidth-1:0]       host_addr_i,
    input  logic [NumHosts-1:0]                 host_we_i,
    input  logic [NumHosts*DataWidth-1:0]       host_wdata_i,
    input  logic [NumHosts*(DataWidth/8)-1:0]   host_be_i,
    output logic [NumHosts-1:0]                 host_rsp_valid_o,
    output logic [DataWidth-1:0]                host_rdata_o,
    output logic                                host_err_o,
    output logic                                dev_req_valid_o,
    input  logic                                dev_req_ready_i,
    output logic [AddrWidth-1:0]                dev_addr_o,
    output logic                                dev_we_o,
    output logic [DataWidth-1:0]                dev_wdata_o,
    output logic [DataWidth/8-1:0]              dev_be_o,
    input  logic                                dev_rsp_valid_i,
    input  logic [DataWidth-1:0]                dev_rdata_i,
    input  logic                                dev_err_i,
    output logic [$clog2(MaxOutstanding):0]     outstanding_o,
    output logic                                unexpected_rsp_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdxW    = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int unsigned PtrW    = $clog2(MaxOutstanding);
    localparam int unsigned CntW    = PtrW + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [IdxW-1:0]   r_winner;
    logic [IdxW-1:0]   w_sel;
    logic              w_sel_vld;
    logic              w_full;
    logic              w_accept;
    logic              w_pop;
    logic [IdxW-1:0]   r_fifo [MaxOutstanding];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic              r_unexp;
`ifndef SPAD_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0]   r_rr_ptr;
`endif

    assign w_full           = (r_count == CntW'(MaxOutstanding));
    assign outstanding_o    = r_count;
    assign unexpected_rsp_o = r_unexp;
    // Response payload is a straight pass-through; only the strobe is routed.
    assign host_rdata_o     = dev_rdata_i;
    assign host_err_o       = dev_err_i;

    // Winner selection: held winner when LOCKED, otherwise arbitrate.
    always_comb begin : sel_logic
`ifndef SPAD_ARB_FIXED_PRIO_EN
        int unsigned v_idx;
        v_idx = 0;
`endif
        w_sel     = '0;
        w_sel_vld = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_sel     = r_winner;
            w_sel_vld = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NumHosts; i++) begin
`ifdef SPAD_ARB_FIXED_PRIO_EN
                if (!w_sel_vld && host_req_valid_i[IdxW'(i)]) begin
                    w_sel     = IdxW'(i);
                    w_sel_vld = 1'b1;
                end
`else
                // Scan from the pointer so the last winner has lowest priority.
                v_idx = (32'(r_rr_ptr) + i) % NumHosts;
                if (!w_sel_vld && host_req_valid_i[IdxW'(v_idx)]) begin
                    w_sel     = IdxW'(v_idx);
                    w_sel_vld = 1'b1;
                end
`endif
            end
        end
    end

    // Mux the selected host's request fields onto the device port.
    always_comb begin : field_mux
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_wdata_o = '0;
        dev_be_o    = '0;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            if (w_sel == IdxW'(i)) begin
                dev_addr_o  = host_addr_i[i*AddrWidth +: AddrWidth];
                dev_we_o    = host_we_i[IdxW'(i)];
                dev_wdata_o = host_wdata_i[i*DataWidth +: DataWidth];
                dev_be_o    = host_be_i[i*BeWidth +: BeWidth];
            end
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin : fsm_comb
        w_state_next     = r_state;
        dev_req_valid_o  = 1'b0;
        host_req_ready_o = '0;
        host_rsp_valid_o = '0;
        w_accept         = 1'b0;
        w_pop            = 1'b0;

        // A full FIFO blocks issue even if a pop frees a slot this cycle.
        dev_req_valid_o = w_sel_vld && !w_full && !rst_sys_i;
        w_accept        = dev_req_valid_o && dev_req_ready_i;
        if (w_accept) begin
            host_req_ready_o[w_sel] = 1'b1;
        end

        w_pop = dev_rsp_valid_i && (r_count != '0) && !rst_sys_i;
        if (w_pop) begin
            host_rsp_valid_o[r_fifo[r_rd_ptr]] = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (dev_req_valid_o && !dev_req_ready_i) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Held winner, arbitration pointer, FIFO pointers and count.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_winner <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_unexp  <= 1'b0;
`ifndef SPAD_ARB_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`endif
        end else begin
            if (r_state == ST_IDLE) begin
                r_winner <= w_sel;
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
`ifndef SPAD_ARB_FIXED_PRIO_EN
                if (32'(w_sel) == NumHosts - 1) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_sel + IdxW'(1);
                end
`endif
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_accept) - CntW'(w_pop);
            r_unexp <= dev_rsp_valid_i && (r_count == '0);
        end
    end

    // Routing FIFO storage; contents are only meaningful below r_count.
    always_ff @(posedge clk_sys_i) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

endmodule

// File: tb/tb_spad_arbiter.sv
module tb_spad_arbiter;

    localparam logic [31:0] ADDR0  = 32'h1000_0040;
    localparam logic [31:0] ADDR1  = 32'h2000_0080;
    localparam logic [31:0] WDATA1 = 32'hDEAD_0001;

    typedef struct {
        int          host;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  host_req_valid;
    logic [1:0]  host_req_ready;
    logic [63:0] host_addr;
    logic [1:0]  host_we;
    logic [63:0] host_wdata;
    logic [7:0]  host_be;
    logic [1:0]  host_rsp_valid;
    logic [31:0] host_rdata;
    logic        host_err;
    logic        dev_req_valid;
    logic        dev_req_ready;
    logic [31:0] dev_addr;
    logic        dev_we;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_be;
    logic        dev_rsp_valid;
    logic [31:0] dev_rdata;
    logic        dev_err;
    logic [2:0]  outstanding;
    logic        unexpected_rsp;

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t exp_rsp_q[$];
    int   exp_grant_q[$];

    spad_arbiter dut (
        .clk_sys_i        (clk),
        .rst_sys_i        (rst),
        .host_req_valid_i (host_req_valid),
        .host_req_ready_o (host_req_ready),
        .host_addr_i      (host_addr),
        .host_we_i        (host_we),
        .host_wdata_i     (host_wdata),
        .host_be_i        (host_be),
        .host_rsp_valid_o (host_rsp_valid),
        .host_rdata_o     (host_rdata),
        .host_err_o       (host_err),
        .dev_req_valid_o  (dev_req_valid),
        .dev_req_ready_i  (dev_req_ready),
        .dev_addr_o       (dev_addr),
        .dev_we_o         (dev_we),
        .dev_wdata_o      (dev_wdata),
        .dev_be_o         (dev_be),
        .dev_rsp_valid_i  (dev_rsp_valid),
        .dev_rdata_i      (dev_rdata),
        .dev_err_i        (dev_err),
        .outstanding_o    (outstanding),
        .unexpected_rsp_o (unexpected_rsp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] oh(input int h);
        oh = 2'(1) << h;
    endfunction

    function automatic logic [31:0] addr_of(input int h);
        addr_of = (h == 0) ? ADDR0 : ADDR1;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; host_req_valid = 2'b11; dev_req_ready = 1'b1; dev_rsp_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (dev_req_valid !== 1'b0 || host_req_ready !== 2'b00 || host_rsp_valid !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_hold: dev_req_valid=%b req_ready=%b rsp_valid=%b required 0/00/00",
                         dev_req_valid, host_req_ready, host_rsp_valid);
            end
            tick();
        end
        rst = 1'b0; host_req_valid = 2'b00; dev_req_ready = 1'b0; dev_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (outstanding !== 3'd0 || unexpected_rsp !== 1'b0 || dev_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: outstanding=%0d unexpected=%b dev_req_valid=%b required 0/0/0",
                     outstanding, unexpected_rsp, dev_req_valid);
        end
        tick();
    endtask

    task automatic test_rr_alternate();
        rsp_t e;
        int   g;
        for (int i = 0; i < 6; i++) begin
`ifdef SPAD_ARB_FIXED_PRIO_EN
            exp_grant_q.push_back(0);
`else
            exp_grant_q.push_back(i % 2);
`endif
        end
        dev_req_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            host_req_valid = (c < 6) ? 2'b11 : 2'b00;
            dev_rsp_valid  = (c > 0);
            dev_rdata      = 32'hB0 + 32'(c - 1);
            #1;
            if (c > 0 && exp_rsp_q.size() > 0) begin
                e = exp_rsp_q.pop_front();
                n_checks++;
                if (host_rsp_valid !== oh(e.host) || host_rdata !== e.data) begin
                    n_errors++;
                    $display("FAIL rr_rsp: strobe=%b data=%h required strobe=%b data=%h",
                             host_rsp_valid, host_rdata, oh(e.host), e.data);
                end
            end
            if (c < 6) begin
                g = exp_grant_q.pop_front();
                n_checks++;
                if (host_req_ready !== oh(g) || dev_addr !== addr_of(g)) begin
                    n_errors++;
                    $display("FAIL rr_grant[%0d]: req_ready=%b addr=%h required req_ready=%b addr=%h",
                             c, host_req_ready, dev_addr, oh(g), addr_of(g));
                end
                e.host = g; e.data = 32'hB0 + 32'(c); e.err = 1'b0;
                exp_rsp_q.push_back(e);
            end else begin
                n_checks++;
                if (dev_req_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rr_idle: dev_req_valid=%b required 0", dev_req_valid);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (outstanding !== 3'd1) begin
                    n_errors++;
                    $display("FAIL rr_push_pop: outstanding=%0d required 1", outstanding);
                end
            end
            tick();
        end
        dev_rsp_valid = 1'b0; dev_req_ready = 1'b0;
        #1;
        n_checks++;
        if (outstanding !== 3'd0) begin
            n_errors++;
            $display("FAIL rr_drain: outstanding=%0d required 0", outstanding);
        end
        tick();
    endtask

    task automatic test_locked();
        rsp_t e;
        for (int c = 0; c < 3; c++) begin
            host_req_valid = (c == 0) ? 2'b10 : 2'b11;
            dev_req_ready  = 1'b0;
            #1;
            n_checks++;
            if (dev_req_valid !== 1'b1 || dev_addr !== ADDR1 || dev_we !== 1'b1 ||
                dev_wdata !== WDATA1 || host_req_ready !== 2'b00) begin
                n_errors++;
                $display("FAIL lock_hold[%0d]: valid=%b addr=%h we=%b wdata=%h req_ready=%b required 1/%h/1/%h/00",
                         c, dev_req_valid, dev_addr, dev_we, dev_wdata, host_req_ready, ADDR1, WDATA1);
            end
            tick();
        end
        dev_req_ready = 1'b1;
        #1;
        n_checks++;
        if (host_req_ready !== 2'b10 || dev_addr !== ADDR1) begin
            n_errors++;
            $display("FAIL lock_accept: req_ready=%b addr=%h required 10/%h", host_req_ready, dev_addr, ADDR1);
        end
        e.host = 1; e.data = 32'hC0; e.err = 1'b0; exp_rsp_q.push_back(e);
        tick();
        host_req_valid = 2'b01;
        #1;
        n_checks++;
        if (host_req_ready !== 2'b01 || dev_addr !== ADDR0) begin
            n_errors++;
            $display("FAIL lock_next: req_ready=%b addr=%h required 01/%h", host_req_ready, dev_addr, ADDR0);
        end
        e.host = 0; e.data = 32'hC1; e.err = 1'b0; exp_rsp_q.push_back(e);
        tick();
        host_req_valid = 2'b00; dev_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dev_rsp_valid = 1'b1; dev_rdata = 32'hC0 + 32'(k);
            #1;
            e = exp_rsp_q.pop_front();
            n_checks++;
            if (host_rsp_valid !== oh(e.host) || host_rdata !== e.data) begin
                n_errors++;
                $display("FAIL lock_rsp[%0d]: strobe=%b data=%h required strobe=%b data=%h",
                         k, host_rsp_valid, host_rdata, oh(e.host), e.data);
            end
            tick();
        end
        dev_rsp_valid = 1'b0;
        tick();
    endtask

    task automatic test_full();
        rsp_t e;
        host_req_valid = 2'b01; dev_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (host_req_ready !== 2'b01) begin
                n_errors++;
                $display("FAIL full_fill[%0d]: req_ready=%b required 01", c, host_req_ready);
            end
            e.host = 0; e.data = 32'hD0 + 32'(c); e.err = 1'b0; exp_rsp_q.push_back(e);
            tick();
        end
        #1;
        n_checks++;
        if (outstanding !== 3'd4 || dev_req_valid !== 1'b0 || host_req_ready !== 2'b00) begin
            n_errors++;
            $display("FAIL full_stall: outstanding=%0d valid=%b req_ready=%b required 4/0/00",
                     outstanding, dev_req_valid, host_req_ready);
        end
        tick();
        dev_rsp_valid = 1'b1; dev_rdata = 32'hD0;
        #1;
        e = exp_rsp_q.pop_front();
        n_checks++;
        if (host_rsp_valid !== oh(e.host) || host_rdata !== e.data || dev_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL full_pop_defer: strobe=%b data=%h valid=%b required %b/%h/0",
                     host_rsp_valid, host_rdata, dev_req_valid, oh(e.host), e.data);
        end
        tick();
        dev_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (dev_req_valid !== 1'b1 || host_req_ready !== 2'b01 || outstanding !== 3'd3) begin
            n_errors++;
            $display("FAIL full_resume: valid=%b req_ready=%b outstanding=%0d required 1/01/3",
                     dev_req_valid, host_req_ready, outstanding);
        end
        e.host = 0; e.data = 32'hD4; e.err = 1'b0; exp_rsp_q.push_back(e);
        tick();
        host_req_valid = 2'b00; dev_req_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            dev_rsp_valid = 1'b1; dev_rdata = 32'hD0 + 32'(k);
            #1;
            e = exp_rsp_q.pop_front();
            n_checks++;
            if (host_rsp_valid !== oh(e.host) || host_rdata !== e.data) begin
                n_errors++;
                $display("FAIL full_drain[%0d]: strobe=%b data=%h required strobe=%b data=%h",
                         k, host_rsp_valid, host_rdata, oh(e.host), e.data);
            end
            tick();
        end
        dev_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (outstanding !== 3'd0) begin
            n_errors++;
            $display("FAIL full_empty: outstanding=%0d required 0", outstanding);
        end
        tick();
    endtask

    task automatic test_order();
        rsp_t e;
        int   seq[4];
        seq = '{0, 1, 1, 0};
        dev_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            host_req_valid = oh(seq[c]);
            #1;
            n_checks++;
            if (host_req_ready !== oh(seq[c])) begin
                n_errors++;
                $display("FAIL order_grant[%0d]: req_ready=%b required %b", c, host_req_ready, oh(seq[c]));
            end
            e.host = seq[c]; e.data = 32'hA0 + 32'(c); e.err = (c == 2);
            exp_rsp_q.push_back(e);
            tick();
        end
        host_req_valid = 2'b00; dev_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dev_rsp_valid = 1'b1; dev_rdata = 32'hA0 + 32'(k); dev_err = (k == 2);
            #1;
            e = exp_rsp_q.pop_front();
            n_checks++;
            if (host_rsp_valid !== oh(e.host) || host_rdata !== e.data || host_err !== e.err) begin
                n_errors++;
                $display("FAIL order_rsp[%0d]: strobe=%b data=%h err=%b required strobe=%b data=%h err=%b",
                         k, host_rsp_valid, host_rdata, host_err, oh(e.host), e.data, e.err);
            end
            tick();
        end
        dev_rsp_valid = 1'b0; dev_err = 1'b0;
        tick();
    endtask

    task automatic test_unexpected();
        dev_rsp_valid = 1'b1; dev_rdata = 32'hEE;
        #1;
        n_checks++;
        if (host_rsp_valid !== 2'b00) begin
            n_errors++;
            $display("FAIL unexp_strobe: strobe=%b required 00", host_rsp_valid);
        end
        tick();
        dev_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (unexpected_rsp !== 1'b1 || outstanding !== 3'd0 || host_rsp_valid !== 2'b00) begin
            n_errors++;
            $display("FAIL unexp_pulse: unexpected=%b outstanding=%0d strobe=%b required 1/0/00",
                     unexpected_rsp, outstanding, host_rsp_valid);
        end
        tick();
        #1;
        n_checks++;
        if (unexpected_rsp !== 1'b0) begin
            n_errors++;
            $display("FAIL unexp_single: unexpected=%b required 0", unexpected_rsp);
        end
        tick();
    endtask

    task automatic test_reset_locked();
        rsp_t e;
        dev_req_ready = 1'b1;
        host_req_valid = 2'b10; tick();
        host_req_valid = 2'b01; tick();
        host_req_valid = 2'b10; dev_req_ready = 1'b0;
        #1;
        n_checks++;
        if (outstanding !== 3'd2 || dev_req_valid !== 1'b1 || dev_addr !== ADDR1) begin
            n_errors++;
            $display("FAIL rstlk_setup: outstanding=%0d valid=%b addr=%h required 2/1/%h",
                     outstanding, dev_req_valid, dev_addr, ADDR1);
        end
        tick();
        rst = 1'b1;
        exp_rsp_q.delete();
        #1;
        n_checks++;
        if (dev_req_valid !== 1'b0 || host_req_ready !== 2'b00) begin
            n_errors++;
            $display("FAIL rstlk_hold: valid=%b req_ready=%b required 0/00", dev_req_valid, host_req_ready);
        end
        tick();
        rst = 1'b0; host_req_valid = 2'b00;
        #1;
        n_checks++;
        if (dev_req_valid !== 1'b0 || host_req_ready !== 2'b00 || host_rsp_valid !== 2'b00 ||
            outstanding !== 3'd0 || unexpected_rsp !== 1'b0) begin
            n_errors++;
            $display("FAIL rstlk_clear: valid=%b req_ready=%b strobe=%b outstanding=%0d unexpected=%b required all 0",
                     dev_req_valid, host_req_ready, host_rsp_valid, outstanding, unexpected_rsp);
        end
        tick();
        host_req_valid = 2'b11;
        #1;
        n_checks++;
        if (dev_req_valid !== 1'b1 || dev_addr !== ADDR0) begin
            n_errors++;
            $display("FAIL rstlk_rr_restart: valid=%b addr=%h required 1/%h", dev_req_valid, dev_addr, ADDR0);
        end
        tick();
        dev_req_ready = 1'b1;
        #1;
        n_checks++;
        if (host_req_ready !== 2'b01) begin
            n_errors++;
            $display("FAIL rstlk_grant: req_ready=%b required 01", host_req_ready);
        end
        e.host = 0; e.data = 32'hF0; e.err = 1'b0; exp_rsp_q.push_back(e);
        tick();
        host_req_valid = 2'b00; dev_req_ready = 1'b0;
        dev_rsp_valid = 1'b1; dev_rdata = 32'hF0;
        #1;
        e = exp_rsp_q.pop_front();
        n_checks++;
        if (host_rsp_valid !== oh(e.host) || host_rdata !== e.data) begin
            n_errors++;
            $display("FAIL rstlk_rsp: strobe=%b data=%h required strobe=%b data=%h",
                     host_rsp_valid, host_rdata, oh(e.host), e.data);
        end
        tick();
        dev_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (outstanding !== 3'd0 || exp_rsp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rstlk_end: outstanding=%0d pending=%0d required 0/0", outstanding, exp_rsp_q.size());
        end
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        host_req_valid = 2'b00;
        host_addr      = {ADDR1, ADDR0};
        host_we        = 2'b10;
        host_wdata     = {WDATA1, 32'h0};
        host_be        = {4'hF, 4'h3};
        dev_req_ready  = 1'b0;
        dev_rsp_valid  = 1'b0;
        dev_rdata      = '0;
        dev_err        = 1'b0;
        test_reset();
        test_rr_alternate();
        test_locked();
        test_full();
        test_order();
        test_unexpected();
        test_reset_locked();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spad_arbiter.md
SPAD_ARBITER -- requirements
Module: spad_arbiter

Interface
REQ-001 SHALL have parameter NumHosts, default 2, number of requesting hosts (index 0 = core data, 1 = core instr).
REQ-002 SHALL have parameter AddrWidth, default 32, request address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width; byte enables are DataWidth/8 bits.
REQ-004 SHALL have parameter MaxOutstanding, default 4, depth of the response-routing FIFO; must be a power of two, >= 2.
REQ-005 SHALL have ports: clk_sys_i in 1 system clock; rst_sys_i in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: host_req_valid_i in NumHosts, per-host request valid; host_req_ready_o out NumHosts, per-host request accepted.
REQ-007 SHALL have ports: host_addr_i in NumHosts*AddrWidth; host_we_i in NumHosts; host_wdata_i in NumHosts*DataWidth; host_be_i in NumHosts*DataWidth/8, packed per-host request fields.
REQ-008 SHALL have ports: host_rsp_valid_o out NumHosts, one-hot response strobe; host_rdata_o out DataWidth, shared response data; host_err_o out 1, shared response error.
REQ-009 SHALL have ports: dev_req_valid_o out 1; dev_req_ready_i in 1; dev_addr_o out AddrWidth; dev_we_o out 1; dev_wdata_o out DataWidth; dev_be_o out DataWidth/8, downstream scratchpad request.
REQ-010 SHALL have ports: dev_rsp_valid_i in 1; dev_rdata_i in DataWidth; dev_err_i in 1, in-order downstream response.
REQ-011 SHALL have ports: outstanding_o out $clog2(MaxOutstanding)+1, in-flight count; unexpected_rsp_o out 1, single-cycle error pulse.

Function
REQ-012 SHALL implement two states: IDLE (no grant held) and LOCKED (grant held, dev_req_valid_o high, not yet accepted).
REQ-013 SHALL, in IDLE, select a winner among asserted host_req_valid_i by round-robin starting at the pointer; with no valid host, dev_req_valid_o = 0.
REQ-014 SHALL drive dev_req_valid_o = 1 only when a host is selected and outstanding_o < MaxOutstanding; dev_* fields mux the selected host's fields.
REQ-015 SHALL complete a transfer when dev_req_valid_o & dev_req_ready_i; host_req_ready_o is one-hot for the winner that same cycle, else all zero.
REQ-016 SHALL, if dev_req_valid_o is high without ready, enter LOCKED; the winner and all dev_* outputs stay frozen until acceptance, regardless of other hosts' valids.
REQ-017 SHALL return to IDLE on acceptance; the RR pointer then moves to (winner+1) mod NumHosts.
REQ-018 SHALL push the winner's index into the routing FIFO on every accepted transfer (reads and writes both produce a response).
REQ-019 SHALL, on dev_rsp_valid_i with FIFO non-empty, pop the head, assert host_rsp_valid_o[head] for that cycle, pass dev_rdata_i/dev_err_i combinationally (zero added latency).
REQ-020 SHALL, on dev_rsp_valid_i with FIFO empty, drop the response, keep host_rsp_valid_o = 0, pulse unexpected_rsp_o for one cycle.
REQ-021 SHALL, when full, deassert dev_req_valid_o even if a pop occurs that cycle; acceptance resumes the following cycle.
REQ-022 SHALL support simultaneous push and pop when not full; outstanding_o unchanged.
REQ-023 SHALL wrap FIFO read/write pointers modulo MaxOutstanding; host_rdata_o/host_err_o are don't-care when no strobe.

Reset
REQ-024 SHALL, on rst_sys_i high at a clock edge, enter IDLE, RR pointer = 0, FIFO empty, outstanding_o = 0, unexpected_rsp_o = 0.
REQ-025 SHALL, during reset, hold dev_req_valid_o, host_req_ready_o, host_rsp_valid_o at 0; a reset while LOCKED abandons the pending request.

Configuration
REQ-026 SHALL use macro SPAD_ARB_FIXED_PRIO_EN: when defined, selection is fixed priority (lowest index wins) and the RR pointer is absent; when undefined, round-robin per REQ-013/REQ-017.

Verification
REQ-027 SHALL cover: both hosts valid continuously, dev_req_ready_i = 1 -> grants alternate 0,1,0,1 (macro undefined); all to host 0 (macro defined).
REQ-028 SHALL cover: host 1 alone, dev_req_ready_i low 3 cycles while host 0 raises valid -> dev_addr_o stays host 1's, host 1 accepted on cycle 4, host 0 next.
REQ-029 SHALL cover: 4 accepted reads, no responses -> outstanding_o = 4, dev_req_valid_o = 0; one response with a same-cycle request -> request deferred one cycle.
REQ-030 SHALL cover: grants 0,1,1,0 then 4 responses with rdata 0xA0..0xA3 -> host_rsp_valid_o = 01,10,10,01 with matching data in order.
REQ-031 SHALL cover: dev_rsp_valid_i with empty FIFO -> unexpected_rsp_o pulses 1 cycle, no host strobe, outstanding_o stays 0.
REQ-032 SHALL cover: rst_sys_i asserted while LOCKED with 2 outstanding -> next cycle all outputs 0, outstanding_o = 0, RR restarts at host 0.
